// File: rtl/attention_score_stream_int.sv
// Streaming MX-int attention scores: buffers K^T columns, computes one column dot product per
// cycle for each accepted Q row, then aligns the row to one shared exponent for the softmax.
module attention_score_stream_int #(
    parameter int S_KV        = 4,
    parameter int D_KQ        = 8,
    parameter int K           = 2,
    parameter int BIT_WIDTH   = 8,
    parameter int OUT_WIDTH   = 16,
    parameter int SCALE_WIDTH = 8,
    parameter int CAUSAL      = 0
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_kt_valid,
    output logic                                o_kt_ready,
    input  logic [D_KQ*BIT_WIDTH-1:0]           i_kt_col,
    input  logic [(D_KQ/K)*SCALE_WIDTH-1:0]     i_s_kt,
    input  logic                                i_kt_clear,
    input  logic                                i_q_valid,
    output logic                                o_q_ready,
    input  logic [D_KQ*BIT_WIDTH-1:0]           i_q,
    input  logic [(D_KQ/K)*SCALE_WIDTH-1:0]     i_s_q,
    input  logic [$clog2(S_KV):0]               i_q_pos,
    output logic                                o_score_valid,
    input  logic                                i_score_ready,
    output logic [S_KV*OUT_WIDTH-1:0]           o_score,
    output logic [SCALE_WIDTH-1:0]              o_score_exp
);

    localparam int NB      = D_KQ / K;
    localparam int AW      = 2 * BIT_WIDTH + $clog2(D_KQ);
    localparam int EW      = SCALE_WIDTH + 1;
    localparam int CW      = (S_KV > 1) ? $clog2(S_KV) : 1;
    localparam int PW      = $clog2(S_KV) + 1;
    localparam int HALF    = $clog2(D_KQ) / 2;
    localparam int EXP_MAX = (2 ** SCALE_WIDTH) - 1;

    localparam logic [CW-1:0]        LAST     = CW'(S_KV - 1);
    localparam logic signed [AW-1:0] SAT_MAX  = AW'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_MIN  = ~SAT_MAX;
    localparam logic [OUT_WIDTH-1:0] MASK_VAL = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_READY,
        ST_SCORE,
        ST_ALIGN,
        ST_OUT
    } state_t;

    state_t state, next_state;

    logic [CW-1:0]                   cnt;
    logic [D_KQ*BIT_WIDTH-1:0]       kt_buf      [S_KV];
    logic [NB*SCALE_WIDTH-1:0]       kts_buf     [S_KV];
    logic signed [AW-1:0]            acc_buf     [S_KV];
    logic [EW-1:0]                   col_exp_buf [S_KV];
    logic [D_KQ*BIT_WIDTH-1:0]       q_row;
    logic [NB*SCALE_WIDTH-1:0]       q_scale;
    logic [S_KV-1:0]                 mask;
    logic [S_KV-1:0]                 new_mask;
    logic [S_KV*OUT_WIDTH-1:0]       score_reg;
    logic [SCALE_WIDTH-1:0]          exp_reg;

    logic [D_KQ*BIT_WIDTH-1:0]       kt_sel;
    logic [NB*SCALE_WIDTH-1:0]       kts_sel;
    logic signed [AW-1:0]            blk_sum [NB];
    logic [EW-1:0]                   blk_exp [NB];
    logic [EW-1:0]                   col_exp;
    logic signed [AW-1:0]            col_acc;
    logic [EW-1:0]                   row_exp;
    logic [S_KV*OUT_WIDTH-1:0]       aligned;
    logic [SCALE_WIDTH-1:0]          exp_clamped;

    // Shifts past the accumulator width collapse to the sign fill (0 or -1).
    function automatic logic signed [AW-1:0] asr(input logic signed [AW-1:0] v,
                                                 input logic [EW-1:0] sh);
        if (sh >= EW'(AW)) begin
            return v[AW-1] ? '1 : '0;
        end
        return v >>> sh;
    endfunction

    function automatic logic [OUT_WIDTH-1:0] sat(input logic signed [AW-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[OUT_WIDTH-1:0];
        end
        if (v < SAT_MIN) begin
            return SAT_MIN[OUT_WIDTH-1:0];
        end
        return v[OUT_WIDTH-1:0];
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        o_kt_ready    = 1'b0;
        o_q_ready     = 1'b0;
        o_score_valid = 1'b0;
        case (state)
            ST_LOAD: begin
                o_kt_ready = 1'b1;
                if (i_kt_valid && cnt == LAST) begin
                    next_state = ST_READY;
                end
            end
            ST_READY: begin
                o_q_ready = 1'b1;
                if (i_kt_clear) begin
                    next_state = ST_LOAD;
                end else if (i_q_valid) begin
                    next_state = ST_SCORE;
                end
            end
            ST_SCORE: begin
                if (cnt == LAST) begin
                    next_state = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                next_state = ST_OUT;
            end
            ST_OUT: begin
                o_score_valid = 1'b1;
                if (i_score_ready) begin
                    next_state = ST_READY;
                end
            end
            default: next_state = ST_LOAD;
        endcase
    end

    assign kt_sel  = kt_buf[cnt];
    assign kts_sel = kts_buf[cnt];

    // Column j of the score: per-block sums aligned to the largest block exponent.
    always_comb begin
        col_exp = '0;
        col_acc = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            blk_sum[b] = '0;
            for (int unsigned k = 0; k < K; k++) begin
                blk_sum[b] = blk_sum[b] + AW'($signed(q_row[(b*K+k)*BIT_WIDTH +: BIT_WIDTH])
                                            * $signed(kt_sel[(b*K+k)*BIT_WIDTH +: BIT_WIDTH]));
            end
            blk_exp[b] = EW'(q_scale[b*SCALE_WIDTH +: SCALE_WIDTH])
                       + EW'(kts_sel[b*SCALE_WIDTH +: SCALE_WIDTH]);
            if (blk_exp[b] > col_exp) begin
                col_exp = blk_exp[b];
            end
        end
        for (int unsigned b = 0; b < NB; b++) begin
            col_acc = col_acc + asr(blk_sum[b], col_exp - blk_exp[b]);
        end
    end

    always_comb begin
        new_mask = '0;
        for (int unsigned j = 0; j < S_KV; j++) begin
            if (CAUSAL != 0 && i_q_pos < PW'(S_KV - 1) && PW'(j) > i_q_pos) begin
                new_mask[j] = 1'b1;
            end
        end
    end

    // Masked columns are excluded from the row exponent; column 0 is never masked.
    always_comb begin
        row_exp     = '0;
        aligned     = '0;
        exp_clamped = '0;
        for (int unsigned j = 0; j < S_KV; j++) begin
            if (!mask[j] && col_exp_buf[j] > row_exp) begin
                row_exp = col_exp_buf[j];
            end
        end
        for (int unsigned j = 0; j < S_KV; j++) begin
            aligned[j*OUT_WIDTH +: OUT_WIDTH] = mask[j] ? MASK_VAL
                                              : sat(asr(acc_buf[j], row_exp - col_exp_buf[j]));
        end
        if (row_exp < EW'(HALF)) begin
            exp_clamped = '0;
        end else if (row_exp - EW'(HALF) > EW'(EXP_MAX)) begin
            exp_clamped = '1;
        end else begin
            exp_clamped = SCALE_WIDTH'(row_exp - EW'(HALF));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt       <= '0;
            q_row     <= '0;
            q_scale   <= '0;
            mask      <= '0;
            score_reg <= '0;
            exp_reg   <= '0;
            for (int unsigned j = 0; j < S_KV; j++) begin
                kt_buf[j]      <= '0;
                kts_buf[j]     <= '0;
                acc_buf[j]     <= '0;
                col_exp_buf[j] <= '0;
            end
        end else begin
            case (state)
                ST_LOAD: begin
                    if (i_kt_valid) begin
                        kt_buf[cnt]  <= i_kt_col;
                        kts_buf[cnt] <= i_s_kt;
                        cnt          <= (cnt == LAST) ? '0 : cnt + CW'(1);
                    end
                end
                ST_READY: begin
                    if (i_kt_clear) begin
                        cnt <= '0;
                    end else if (i_q_valid) begin
                        q_row   <= i_q;
                        q_scale <= i_s_q;
                        mask    <= new_mask;
                        cnt     <= '0;
                    end
                end
                ST_SCORE: begin
                    acc_buf[cnt]     <= col_acc;
                    col_exp_buf[cnt] <= col_exp;
                    cnt              <= (cnt == LAST) ? '0 : cnt + CW'(1);
                end
                ST_ALIGN: begin
                    score_reg <= aligned;
                    exp_reg   <= exp_clamped;
                end
                default: ;
            endcase
        end
    end

    assign o_score     = score_reg;
    assign o_score_exp = exp_reg;

endmodule

// File: tb/tb_attention_score_stream_int.sv
// Scoreboard bench for attention_score_stream_int: stimulus pushes expected rows, the monitor
// pops and compares on every score handshake.
module tb_attention_score_stream_int;

    localparam int S_KV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        kt_valid = 1'b0;
    logic        kt_clear = 1'b0;
    logic        q_valid = 1'b0;
    logic        score_ready = 1'b1;
    logic        kt_ready, q_ready, score_valid;
    logic [63:0] kt_col = '0;
    logic [63:0] q = '0;
    logic [31:0] s_kt = '0;
    logic [31:0] s_q = '0;
    logic [2:0]  q_pos = '0;
    logic [63:0] score;
    logic [7:0]  score_exp;

    int          checks = 0;
    int          fails = 0;
    logic [71:0] exp_q[$];
    logic [71:0] mon_e;

    always #5 clk = ~clk;

    attention_score_stream_int #(
        .S_KV(4), .D_KQ(8), .K(2), .BIT_WIDTH(8), .OUT_WIDTH(16), .SCALE_WIDTH(8), .CAUSAL(1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_kt_valid(kt_valid), .o_kt_ready(kt_ready), .i_kt_col(kt_col), .i_s_kt(s_kt),
        .i_kt_clear(kt_clear),
        .i_q_valid(q_valid), .o_q_ready(q_ready), .i_q(q), .i_s_q(s_q), .i_q_pos(q_pos),
        .o_score_valid(score_valid), .i_score_ready(score_ready),
        .o_score(score), .o_score_exp(score_exp)
    );

    function automatic logic [63:0] sc4(input int s0, input int s1, input int s2, input int s3);
        return {16'(s3), 16'(s2), 16'(s1), 16'(s0)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && score_valid && score_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_row: got score %h, expected no row", score);
            end else begin
                mon_e = exp_q.pop_front();
                check("row_score", score, mon_e[71:8]);
                check("row_exp", {56'd0, score_exp}, {56'd0, mon_e[7:0]});
            end
        end
    end

    task automatic wait_q_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (q_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic load_cols(input logic [7:0] kv, input logic [31:0] sc,
                             input int first, input int last);
        bit ok;
        for (int j = first; j <= last; j++) begin
            ok = 1'b0;
            for (int i = 0; i < 50; i++) begin
                if (kt_ready) begin
                    ok = 1'b1;
                    break;
                end
                @(posedge clk); #1;
            end
            check("kt_ready_wait", {63'd0, ok}, 64'd1);
            kt_valid = 1'b1;
            kt_col   = {8{kv}};
            s_kt     = {4{sc[j*8 +: 8]}};
            @(posedge clk); #1;
        end
        kt_valid = 1'b0;
    endtask

    task automatic clear_buf();
        bit ok;
        wait_q_ready(ok);
        check("clear_wait", {63'd0, ok}, 64'd1);
        kt_clear = 1'b1;
        @(posedge clk); #1;
        kt_clear = 1'b0;
        check("clear_kt_ready", {63'd0, kt_ready}, 64'd1);
    endtask

    // Issues one Q row (all elements qv), pushes the expected row, checks valid timing.
    task automatic send_q(input logic [7:0] qv, input logic [31:0] qs, input logic [2:0] pos,
                          input logic [63:0] exp_sc, input logic [7:0] exp_e);
        bit ok;
        wait_q_ready(ok);
        check("q_ready_wait", {63'd0, ok}, 64'd1);
        if (!ok) return;
        q       = {8{qv}};
        s_q     = qs;
        q_pos   = pos;
        q_valid = 1'b1;
        exp_q.push_back({exp_sc, exp_e});
        @(posedge clk); #1;
        q_valid = 1'b0;
        repeat (S_KV + 1) @(negedge clk);
        check("latency_before", {63'd0, score_valid}, 64'd0);
        @(negedge clk);
        check("latency_at", {63'd0, score_valid}, 64'd1);
    endtask

    initial begin
        bit ok;
        #12;
        check("rst_kt_ready", {63'd0, kt_ready}, 64'd1);
        check("rst_q_ready", {63'd0, q_ready}, 64'd0);
        check("rst_valid", {63'd0, score_valid}, 64'd0);
        check("rst_score", score, 64'd0);
        check("rst_exp", {56'd0, score_exp}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Uniform ones, block-level shift, causal masking
        load_cols(8'd1, {4{8'd10}}, 0, 3);
        send_q(8'd1, {4{8'd10}}, 3'd7, sc4(8, 8, 8, 8), 8'd19);
        send_q(8'd1, {8'd10, 8'd10, 8'd12, 8'd10}, 3'd7, sc4(2, 2, 2, 2), 8'd21);
        send_q(8'd1, {4{8'd10}}, 3'd1, sc4(8, 8, -32768, -32768), 8'd19);
        send_q(8'd1, {4{8'd10}}, 3'd0, sc4(8, -32768, -32768, -32768), 8'd19);
        send_q(8'd1, {4{8'd10}}, 3'd3, sc4(8, 8, 8, 8), 8'd19);

        // K^T beats outside LOAD must not disturb the buffer
        wait_q_ready(ok);
        kt_valid = 1'b1;
        kt_col   = {8{8'h55}};
        s_kt     = {4{8'd200}};
        repeat (2) @(posedge clk);
        #1;
        kt_valid = 1'b0;
        send_q(8'd1, {4{8'd10}}, 3'd7, sc4(8, 8, 8, 8), 8'd19);

        clear_buf();
        load_cols(8'd1, {8'd10, 8'd10, 8'd12, 8'd10}, 0, 3);
        send_q(8'd1, {4{8'd10}}, 3'd7, sc4(2, 8, 2, 2), 8'd21);

        // Masked column with the largest exponent must not set the row exponent
        clear_buf();
        load_cols(8'd1, {8'd14, 8'd10, 8'd10, 8'd10}, 0, 3);
        send_q(8'd1, {4{8'd10}}, 3'd1, sc4(8, 8, -32768, -32768), 8'd19);
        send_q(8'd1, {4{8'd10}}, 3'd7, sc4(0, 0, 0, 8), 8'd23);

        // Saturation
        clear_buf();
        load_cols(8'd127, {4{8'd10}}, 0, 3);
        send_q(8'd127, {4{8'd10}}, 3'd7, sc4(32767, 32767, 32767, 32767), 8'd19);
        send_q(8'h80, {4{8'd10}}, 3'd7, sc4(-32768, -32768, -32768, -32768), 8'd19);

        // Exponent extremes and over-wide shifts
        clear_buf();
        load_cols(8'd1, {4{8'd255}}, 0, 3);
        send_q(8'd1, {4{8'd255}}, 3'd7, sc4(8, 8, 8, 8), 8'd255);
        clear_buf();
        load_cols(8'd1, {8'd0, 8'd0, 8'd255, 8'd0}, 0, 3);
        send_q(8'hFF, {4{8'd0}}, 3'd7, sc4(-1, -8, -1, -1), 8'd254);
        send_q(8'd1, {4{8'd0}}, 3'd7, sc4(0, 8, 0, 0), 8'd254);
        clear_buf();
        load_cols(8'd1, {4{8'd0}}, 0, 3);
        send_q(8'd1, {4{8'd0}}, 3'd7, sc4(8, 8, 8, 8), 8'd0);

        // Back-pressure
        clear_buf();
        load_cols(8'd1, {4{8'd10}}, 0, 3);
        score_ready = 1'b0;
        send_q(8'd1, {4{8'd10}}, 3'd7, sc4(8, 8, 8, 8), 8'd19);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {63'd0, score_valid}, 64'd1);
            check("hold_score", score, sc4(8, 8, 8, 8));
            check("hold_exp", {56'd0, score_exp}, 64'd19);
            check("hold_q_ready", {63'd0, q_ready}, 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        score_ready = 1'b1;
        @(posedge clk); #1;
        check("post_valid", {63'd0, score_valid}, 64'd0);
        check("post_score", score, sc4(8, 8, 8, 8));
        check("post_q_ready", {63'd0, q_ready}, 64'd1);

        // Clear beats a simultaneous Q
        q_valid  = 1'b1;
        kt_clear = 1'b1;
        q        = {8{8'd2}};
        s_q      = {4{8'd10}};
        @(posedge clk); #1;
        q_valid  = 1'b0;
        kt_clear = 1'b0;
        check("clrwin_kt_ready", {63'd0, kt_ready}, 64'd1);
        check("clrwin_q_ready", {63'd0, q_ready}, 64'd0);
        repeat (8) @(posedge clk);
        #1;
        check("clrwin_still_load", {63'd0, kt_ready}, 64'd1);
        load_cols(8'd3, {4{8'd10}}, 0, 3);
        send_q(8'd1, {4{8'd10}}, 3'd7, sc4(24, 24, 24, 24), 8'd19);

        // Reset in SCORE cycle 2 drops the in-flight row
        wait_q_ready(ok);
        check("rst_test_q_ready", {63'd0, ok}, 64'd1);
        q       = {8{8'd1}};
        s_q     = {4{8'd10}};
        q_pos   = 3'd7;
        q_valid = 1'b1;
        @(posedge clk); #1;
        q_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_kt_ready", {63'd0, kt_ready}, 64'd1);
        check("mid_rst_q_ready", {63'd0, q_ready}, 64'd0);
        check("mid_rst_valid", {63'd0, score_valid}, 64'd0);
        check("mid_rst_score", score, 64'd0);
        check("mid_rst_exp", {56'd0, score_exp}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        load_cols(8'd2, {4{8'd10}}, 0, 2);
        check("partial_q_ready", {63'd0, q_ready}, 64'd0);
        check("partial_kt_ready", {63'd0, kt_ready}, 64'd1);
        load_cols(8'd2, {4{8'd10}}, 3, 3);
        check("full_q_ready", {63'd0, q_ready}, 64'd1);
        send_q(8'd1, {4{8'd10}}, 3'd7, sc4(16, 16, 16, 16), 8'd19);

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
